// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the tournament branch predictor: opcode match value,
// counter reset value and the 2-bit saturating counter update.
package branch_predictor_pkg;

    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;
    localparam logic [1:0] CTR_RESET     = 2'b01;

    typedef enum logic [1:0] {
        CTR_HOLD = 2'd0,
        CTR_INC  = 2'd1,
        CTR_DEC  = 2'd2
    } ctr_op_e;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input ctr_op_e op);
        logic [1:0] res;
        res = ctr;
        case (op)
            CTR_INC: if (ctr != 2'b11) res = ctr + 2'd1;
            CTR_DEC: if (ctr != 2'b00) res = ctr - 2'd1;
            default: res = ctr;
        endcase
        return res;
    endfunction

    function automatic ctr_op_e outcome_op(input logic taken);
        return taken ? CTR_INC : CTR_DEC;
    endfunction

    // Chooser drifts toward gshare when only bimodal missed, toward bimodal
    // when only gshare missed.
    function automatic ctr_op_e chooser_op(input logic miss1, input logic miss2);
        ctr_op_e op;
        op = CTR_HOLD;
        if (miss1 && !miss2) op = CTR_INC;
        else if (!miss1 && miss2) op = CTR_DEC;
        return op;
    endfunction

endpackage

// File: rtl/branch_predictor_inflight_fifo.sv
// In-order queue of unresolved branches; the head entry is readable
// combinationally so it can be retired in the cycle it resolves.
module bp_inflight_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_CNT);
    assign count = count_reg;
    assign dout  = mem_reg[rd_ptr_reg];

    // A full queue still accepts a push when the head leaves the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (do_push && !do_pop) begin
            count_next = count_reg + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_reg - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/branch_predictor.sv
// Tournament predictor: bimodal and gshare 2-bit counter tables with a
// per-PC chooser, global history recovery on mispredict, in-order retirement.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W   = 6,
    parameter int GHR_W   = 6,
    parameter int Q_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_pc,
    input  logic [31:0]                fetch_inst,
    output logic                       predict1,
    output logic                       predict2,
    output logic                       pprediction,
    output logic                       pred_stall,
    input  logic                       resolve_valid,
    input  logic                       PCsel,
    input  logic                       taken1,
    input  logic                       taken2,
    input  logic                       true,
    output logic [$clog2(Q_DEPTH):0]   inflight
);
    localparam int TBL_SIZE = 2**IDX_W;
    localparam int ENT_W    = 2*IDX_W + GHR_W;

    logic [1:0]       bimodal_reg [TBL_SIZE];
    logic [1:0]       gshare_reg  [TBL_SIZE];
    logic [1:0]       chooser_reg [TBL_SIZE];
    logic [GHR_W-1:0] ghr_reg;
    logic [GHR_W-1:0] ghr_next;

    logic             is_branch;
    logic [IDX_W-1:0] bidx;
    logic [IDX_W-1:0] gidx;
    logic             bim_msb;
    logic             gsh_msb;
    logic             use_gshare;

    logic             q_full;
    logic             q_empty;
    logic             do_push;
    logic             do_pop;
    logic             do_flush;
    logic [ENT_W-1:0] q_din;
    logic [ENT_W-1:0] q_dout;
    logic [IDX_W-1:0] head_bidx;
    logic [IDX_W-1:0] head_gidx;
    logic [GHR_W-1:0] head_snap;

    logic unused_bits;
    assign unused_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0], fetch_inst[31:7]};

    assign is_branch = fetch_valid && (fetch_inst[6:0] == BRANCH_OPCODE);
    assign bidx      = fetch_pc[IDX_W+1:2];
    assign gidx      = bidx ^ ghr_reg;

    assign bim_msb    = bimodal_reg[bidx][1];
    assign gsh_msb    = gshare_reg[gidx][1];
    assign use_gshare = chooser_reg[bidx][1];

    always_comb begin
        predict1    = 1'b0;
        predict2    = 1'b0;
        pprediction = 1'b0;
        if (is_branch) begin
            predict1    = bim_msb;
            predict2    = gsh_msb;
            pprediction = use_gshare ? gsh_msb : bim_msb;
        end
    end

    // Only the oldest branch may resolve; a resolve against an empty queue is
    // a no-op, and a mispredicting resolve squashes everything younger.
    assign do_pop     = resolve_valid && !q_empty && !rst;
    assign do_flush   = do_pop && true;
    assign do_push    = is_branch && !rst && !do_flush && (!q_full || do_pop);
    assign pred_stall = is_branch && !rst && q_full && !do_pop;

    assign q_din = {bidx, gidx, ghr_reg};
    assign {head_bidx, head_gidx, head_snap} = q_dout;

    bp_inflight_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .flush (do_flush),
        .din   (q_din),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (inflight)
    );

    // Recovery rebuilds history from the snapshot taken when the branch was
    // fetched, replacing its speculative bit with the real outcome.
    always_comb begin
        ghr_next = ghr_reg;
        if (do_flush) begin
            ghr_next = {head_snap[GHR_W-2:0], PCsel};
        end else if (do_push) begin
            ghr_next = {ghr_reg[GHR_W-2:0], pprediction};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_reg <= '0;
        end else begin
            ghr_reg <= ghr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TBL_SIZE; i++) begin
                bimodal_reg[i] <= CTR_RESET;
                gshare_reg[i]  <= CTR_RESET;
                chooser_reg[i] <= CTR_RESET;
            end
        end else if (do_pop) begin
            bimodal_reg[head_bidx] <= ctr_update(bimodal_reg[head_bidx], outcome_op(PCsel));
            gshare_reg[head_gidx]  <= ctr_update(gshare_reg[head_gidx], outcome_op(PCsel));
            chooser_reg[head_bidx] <= ctr_update(chooser_reg[head_bidx], chooser_op(taken1, taken2));
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus queues expected
// responses, a negedge monitor pops and compares them.
module tb_branch_predictor;

    localparam logic [31:0] BR_INST  = 32'h00B5_0463;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        predict1;
    logic        predict2;
    logic        pprediction;
    logic        pred_stall;
    logic        resolve_valid;
    logic        PCsel;
    logic        taken1;
    logic        taken2;
    logic        true;
    logic [2:0]  inflight;

    branch_predictor #(
        .IDX_W   (6),
        .GHR_W   (6),
        .Q_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_inst    (fetch_inst),
        .predict1      (predict1),
        .predict2      (predict2),
        .pprediction   (pprediction),
        .pred_stall    (pred_stall),
        .resolve_valid (resolve_valid),
        .PCsel         (PCsel),
        .taken1        (taken1),
        .taken2        (taken2),
        .true          (true),
        .inflight      (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       chk_pred;
        logic       p1;
        logic       p2;
        logic       pp;
        logic       stall;
        logic       chk_cnt;
        logic [2:0] cnt;
        logic       chk_ghr;
        logic [5:0] ghr;
        logic       chk_tbl;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  txn_valid;
    int    n_checks;
    int    n_errors;
    exp_t  cur;
    string cur_name;

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s %s: got %0d, expected %0d", nm, fld, act, exp);
        end
    endtask

    // cp: check predictions; pv = {p1,p2,pp,stall}; cnt/ghr < 0 means unchecked
    function automatic exp_t mk(input bit cp, input logic [3:0] pv, input int cnt,
                                input int ghr, input bit tbl);
        exp_t e;
        e.chk_pred = cp;
        e.p1       = pv[3];
        e.p2       = pv[2];
        e.pp       = pv[1];
        e.stall    = pv[0];
        e.chk_cnt  = (cnt >= 0);
        e.cnt      = cnt[2:0];
        e.chk_ghr  = (ghr >= 0);
        e.ghr      = ghr[5:0];
        e.chk_tbl  = tbl;
        return e;
    endfunction

    // res = {PCsel, taken1, taken2, true}
    task automatic txn(input string nm, input bit f, input bit br, input logic [31:0] pc,
                       input bit r, input logic [3:0] res, input exp_t e);
        fetch_valid   = f;
        fetch_pc      = pc;
        fetch_inst    = br ? BR_INST : NOP_INST;
        resolve_valid = r;
        {PCsel, taken1, taken2, true} = res;
        exp_q.push_back(e);
        name_q.push_back(nm);
        txn_valid = 1'b1;
        @(posedge clk);
        #1;
        txn_valid     = 1'b0;
        fetch_valid   = 1'b0;
        resolve_valid = 1'b0;
        {PCsel, taken1, taken2, true} = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        txn("rst_a", 1, 1, 32'h100, 0, 4'b0000, mk(0, 4'b0000, -1, -1, 0));
        txn("rst_b", 1, 1, 32'h100, 1, 4'b1001, mk(0, 4'b0000, 0, -1, 0));
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (txn_valid) begin
            chk("scoreboard", "has_expectation", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                int bad_b;
                int bad_g;
                int bad_c;
                cur      = exp_q.pop_front();
                cur_name = name_q.pop_front();
                chk(cur_name, "pred_stall", int'(pred_stall), int'(cur.stall));
                if (cur.chk_pred) begin
                    chk(cur_name, "predict1", int'(predict1), int'(cur.p1));
                    chk(cur_name, "predict2", int'(predict2), int'(cur.p2));
                    chk(cur_name, "pprediction", int'(pprediction), int'(cur.pp));
                end
                if (cur.chk_cnt) chk(cur_name, "inflight", int'(inflight), int'(cur.cnt));
                if (cur.chk_ghr) chk(cur_name, "ghr", int'(dut.ghr_reg), int'(cur.ghr));
                if (cur.chk_tbl) begin
                    bad_b = 0;
                    bad_g = 0;
                    bad_c = 0;
                    for (int i = 0; i < 64; i++) begin
                        if (dut.bimodal_reg[i] != 2'b01) bad_b++;
                        if (dut.gshare_reg[i]  != 2'b01) bad_g++;
                        if (dut.chooser_reg[i] != 2'b01) bad_c++;
                    end
                    chk(cur_name, "bimodal_entries_not_01", bad_b, 0);
                    chk(cur_name, "gshare_entries_not_01", bad_g, 0);
                    chk(cur_name, "chooser_entries_not_01", bad_c, 0);
                end
                $display("%0t %-8s p1=%b p2=%b pp=%b stall=%b inflight=%0d ghr=%06b",
                         $time, cur_name, predict1, predict2, pprediction, pred_stall,
                         inflight, dut.ghr_reg);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        txn_valid     = 1'b0;
        rst           = 1'b1;
        fetch_valid   = 1'b0;
        fetch_pc      = '0;
        fetch_inst    = '0;
        resolve_valid = 1'b0;
        {PCsel, taken1, taken2, true} = 4'b0000;
        @(posedge clk);
        #1;

        // Bimodal training at PC 0x100 and chooser movement
        do_reset();
        txn("A1", 1, 1, 32'h100, 0, 4'b0000, mk(1, 4'b0000, 0, 0, 0));
        txn("A2", 0, 0, 32'h0,   0, 4'b0000, mk(0, 4'b0000, 1, 0, 0));
        txn("A3", 0, 0, 32'h0,   1, 4'b1111, mk(0, 4'b0000, 1, -1, 0));
        txn("A4", 1, 1, 32'h100, 0, 4'b0000, mk(1, 4'b1010, 0, 1, 0));
        txn("A5", 0, 0, 32'h0,   1, 4'b1000, mk(0, 4'b0000, 1, 3, 0));
        txn("A6", 1, 1, 32'h100, 0, 4'b0000, mk(1, 4'b1010, 0, 3, 0));
        txn("A7", 0, 0, 32'h0,   1, 4'b0101, mk(0, 4'b0000, 1, 7, 0));
        txn("A8", 1, 1, 32'h100, 0, 4'b0000, mk(1, 4'b1000, 0, 6, 0));
        do_reset();
        txn("A9",  0, 0, 32'h0,   0, 4'b0000, mk(0, 4'b0000, 0, 0, 1));
        txn("A10", 1, 1, 32'h100, 0, 4'b0000, mk(1, 4'b0000, 0, 0, 0));

        // Full queue, stall, push+pop when full, flush priority, read-before-write
        do_reset();
        txn("B1",  1, 1, 32'h100, 0, 4'b0000, mk(1, 4'b0000, 0, 0, 0));
        txn("B2",  1, 1, 32'h104, 0, 4'b0000, mk(1, 4'b0000, 1, 0, 0));
        txn("B3",  1, 1, 32'h108, 0, 4'b0000, mk(1, 4'b0000, 2, 0, 0));
        txn("B4",  1, 1, 32'h10C, 0, 4'b0000, mk(1, 4'b0000, 3, 0, 0));
        txn("B5",  1, 1, 32'h110, 0, 4'b0000, mk(1, 4'b0001, 4, 0, 0));
        txn("B6",  1, 1, 32'h110, 1, 4'b1000, mk(1, 4'b0000, 4, 0, 0));
        txn("B7",  1, 1, 32'h110, 0, 4'b0000, mk(1, 4'b0001, 4, 0, 0));
        txn("B8",  1, 1, 32'h110, 1, 4'b0001, mk(1, 4'b0000, 4, 0, 0));
        txn("B9",  1, 1, 32'h100, 0, 4'b0000, mk(1, 4'b1110, 0, 0, 0));
        txn("B10", 1, 1, 32'h100, 1, 4'b0000, mk(1, 4'b1010, 1, 1, 0));
        txn("B11", 1, 1, 32'h100, 0, 4'b0000, mk(1, 4'b0000, 1, 3, 0));

        // History recovery from snapshot 000101 with three in flight
        do_reset();
        txn("C1",  1, 1, 32'h104, 0, 4'b0000, mk(1, 4'b0000, 0, 0, 0));
        txn("C2",  0, 0, 32'h0,   1, 4'b1001, mk(0, 4'b0000, 1, 0, 0));
        txn("C3",  1, 1, 32'h104, 0, 4'b0000, mk(1, 4'b1010, 0, 1, 0));
        txn("C4",  0, 0, 32'h0,   1, 4'b0001, mk(0, 4'b0000, 1, 3, 0));
        txn("C5",  1, 1, 32'h104, 0, 4'b0000, mk(1, 4'b0000, 0, 2, 0));
        txn("C6",  0, 0, 32'h0,   1, 4'b1001, mk(0, 4'b0000, 1, 4, 0));
        txn("C7",  1, 1, 32'h120, 0, 4'b0000, mk(1, 4'b0000, 0, 5, 0));
        txn("C8",  1, 1, 32'h120, 0, 4'b0000, mk(1, 4'b0000, 1, 10, 0));
        txn("C9",  1, 1, 32'h120, 0, 4'b0000, mk(1, 4'b0000, 2, 20, 0));
        txn("C10", 0, 0, 32'h0,   1, 4'b1001, mk(0, 4'b0000, 3, 40, 0));
        txn("C11", 0, 0, 32'h0,   0, 4'b0000, mk(0, 4'b0000, 0, 11, 0));

        // Chooser saturation at bidx 5, non-branch fetch
        do_reset();
        txn("D1", 1, 1, 32'h14, 0, 4'b0000, mk(1, 4'b0000, 0, 0, 0));
        txn("D2", 0, 0, 32'h0,  1, 4'b1100, mk(0, 4'b0000, 1, 0, 0));
        txn("D3", 1, 1, 32'h14, 0, 4'b0000, mk(1, 4'b1110, 0, 0, 0));
        txn("D4", 0, 0, 32'h0,  1, 4'b1100, mk(0, 4'b0000, 1, 1, 0));
        txn("D5", 1, 1, 32'h14, 0, 4'b0000, mk(1, 4'b1000, 0, 1, 0));
        txn("D6", 0, 0, 32'h0,  1, 4'b1100, mk(0, 4'b0000, 1, 2, 0));
        txn("D7", 1, 0, 32'h14, 0, 4'b0000, mk(1, 4'b0000, 0, 2, 0));
        txn("D8", 1, 1, 32'h14, 0, 4'b0000, mk(1, 4'b1000, 0, 2, 0));

        // Mid-stream reset, then a resolve against an empty queue
        do_reset();
        txn("E1", 0, 0, 32'h0, 0, 4'b0000, mk(0, 4'b0000, 0, 0, 1));
        txn("E2", 0, 0, 32'h0, 1, 4'b1111, mk(0, 4'b0000, 0, 0, 0));
        txn("E3", 0, 0, 32'h0, 0, 4'b0000, mk(0, 4'b0000, 0, 0, 1));

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard", "pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_W, default 6, SHALL set the index width of each counter table (2**IDX_W entries).
REQ-002 Parameter GHR_W, default 6, SHALL set the global history width; GHR_W SHALL equal IDX_W.
REQ-003 Parameter Q_DEPTH, default 4, SHALL set the number of in-flight branch entries (power of two).
REQ-004 clk  in  1  the single clock; every state element updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 fetch_valid  in  1  a fetched instruction is present this cycle.
REQ-007 fetch_pc  in  32  fetch address.
REQ-008 fetch_inst  in  32  fetched instruction word.
REQ-009 predict1  out  1  bimodal prediction (1 = taken).
REQ-010 predict2  out  1  gshare prediction (1 = taken).
REQ-011 pprediction  out  1  chooser-selected final prediction.
REQ-012 pred_stall  out  1  a branch is fetched while the queue is full; fetch holds.
REQ-013 resolve_valid  in  1  the oldest in-flight branch resolves this cycle.
REQ-014 PCsel  in  1  actual outcome of the resolving branch (1 = taken).
REQ-015 taken1 / taken2 / true  in  1 each  mispredict flags for predict1 / predict2 / pprediction.
REQ-016 inflight  out  $clog2(Q_DEPTH)+1  current queue occupancy.

Function
REQ-017 A fetch is a branch when fetch_valid=1 and fetch_inst[6:0]=7'b1100011.
REQ-018 bidx SHALL be fetch_pc[IDX_W+1:2]; gidx SHALL be bidx XOR GHR.
REQ-019 predict1 SHALL be the MSB of bimodal[bidx]; predict2 SHALL be the MSB of gshare[gidx]; both combinational in the fetch cycle.
REQ-020 pprediction SHALL equal predict2 when chooser[bidx] >= 2, and predict1 otherwise.
REQ-021 For a non-branch fetch, all three predictions SHALL be 0.
REQ-022 On a branch fetch with the queue not full and no flush, the block SHALL push {bidx, gidx, GHR snapshot} and shift pprediction into GHR LSB.
REQ-023 pred_stall SHALL be 1 for a branch fetch with the queue full; in that case there is no push and no GHR change.
REQ-024 When resolve_valid=1 with the queue non-empty, the block SHALL pop the head entry and update the tables at that entry's indices.
REQ-025 The bimodal and gshare updates SHALL be 2-bit saturating counters: +1 if PCsel=1 (saturating at 3), -1 otherwise (saturating at 0).
REQ-026 The chooser update SHALL be: +1 (saturating at 3) when taken1=1 and taken2=0; -1 (saturating at 0) when taken1=0 and taken2=1; otherwise unchanged.
REQ-027 If resolve_valid=1 and true=1, the block SHALL flush: empty the queue and set GHR = {snapshot[GHR_W-2:0], PCsel}.
REQ-028 A flush SHALL take priority over a same-cycle push; the push is dropped and pred_stall is 0 that cycle.
REQ-029 A push and a non-flushing pop in the same cycle SHALL both occur, and occupancy is unchanged, including when the queue is full.
REQ-030 resolve_valid with an empty queue SHALL be ignored, with no table, GHR or pointer change.
REQ-031 Queue pointers SHALL wrap modulo Q_DEPTH.
REQ-032 A table write and a read of the same index in the same cycle SHALL return the pre-write value.

Reset
REQ-033 While rst=1, the block SHALL set all bimodal, gshare and chooser entries to 2'b01, GHR to 0, the queue to empty and inflight to 0.
REQ-034 During rst=1, pred_stall SHALL be 0 and no push or pop takes effect.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight entries.

Structure
REQ-036 A shared package SHALL hold the BRANCH opcode constant (7'b1100011), the 2-bit counter reset value and a saturating-update function.
REQ-037 The queue SHALL be one sub-module, bp_inflight_fifo, with push, pop, flush, full, empty and count.

Verification
REQ-038 Reset, then fetch a branch at PC 0x100 -> predict1=0, predict2=0, pprediction=0, inflight=1.
REQ-039 Resolve PC 0x100 taken twice (PCsel=1, taken1=taken2=true=1 on the first resolve; refetch between) -> bimodal[0x00] reaches 3, and predict1=1 on the next fetch.
REQ-040 Push 4 branches, then fetch a 5th -> pred_stall=1, inflight=4; the same cycle with a non-flushing resolve -> pred_stall=0, inflight stays 4.
REQ-041 3 in flight, resolve head with true=1, PCsel=1 and snapshot 6'b000101 -> inflight=0, GHR=6'b001011.
REQ-042 taken1=1, taken2=0 on three resolves at bidx 5 -> chooser[5]=3, and pprediction follows predict2.
REQ-043 resolve_valid=1 with the queue empty -> no state change; assert rst mid-stream -> every table entry reads 2'b01.
